l2_line_beat_serializer: RTL

- Upstream neighbour of the L1-side data-from-L2 buffer control.
- Accepts one full cache-line chunk (BUFFER_WIDTH bits) from the L2 response path and emits it as BUFFER_WIDTH/L2_BUS_WIDTH consecutive L2_BUS_WIDTH beats on the DATA_FROM_L2 valid/ready channel.
- Back-to-back lines stream with zero bubble cycles.
- Honours the global stall enable ENB.

---
 rtl/l2_line_beat_serializer_pkg.sv | 35 +++
 rtl/l2_line_beat_serializer.sv | 108 ++++++++++
 2 files changed

// File: rtl/l2_line_beat_serializer_pkg.sv
// Shared L2->L1 cache package: default bus/line geometry, beat-count
// helpers and the serializer state encoding. Also imported by the
// data-from-L2 buffer control.
package l2_line_beat_serializer_pkg;

  localparam int unsigned DEF_L2_BUS_WIDTH = 64;
  localparam int unsigned DEF_BUFFER_WIDTH = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int unsigned beats_of(input int unsigned buf_w,
                                           input int unsigned bus_w);
    return (bus_w == 0) ? 0 : buf_w / bus_w;
  endfunction

  // Beat index width; a one-bit counter is the floor even for tiny lines.
  function automatic int unsigned cw_of(input int unsigned beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

  // A line must split into a power-of-two count (>= 2) of whole beats.
  function automatic bit line_geometry_ok(input int unsigned buf_w,
                                          input int unsigned bus_w);
    int unsigned beats;
    if (bus_w == 0) return 1'b0;
    if ((buf_w % bus_w) != 0) return 1'b0;
    beats = buf_w / bus_w;
    if (beats < 2) return 1'b0;
    return ((beats & (beats - 1)) == 0);
  endfunction

endpackage

// File: rtl/l2_line_beat_serializer.sv
// Line-to-beat serializer on the L2 response path: takes one BUFFER_WIDTH
// line and emits it as BUFFER_WIDTH/L2_BUS_WIDTH beats on the DATA_FROM_L2
// valid/ready channel, back-to-back lines without bubbles.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (adds LINE_START_BEAT).
module l2_line_beat_serializer
  import l2_line_beat_serializer_pkg::*;
#(
  parameter int unsigned L2_BUS_WIDTH = DEF_L2_BUS_WIDTH,
  parameter int unsigned BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  localparam int unsigned BEATS = beats_of(BUFFER_WIDTH, L2_BUS_WIDTH),
  localparam int unsigned CW    = cw_of(BEATS)
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    ENB,
  input  logic                    LINE_VALID,
  output logic                    LINE_READY,
  input  logic [BUFFER_WIDTH-1:0] LINE_DATA,
`ifdef CRITICAL_WORD_FIRST_EN
  input  logic [CW-1:0]           LINE_START_BEAT,
`endif
  output logic                    DATA_FROM_L2_VALID,
  input  logic                    DATA_FROM_L2_READY,
  output logic [L2_BUS_WIDTH-1:0] DATA_FROM_L2,
  output logic                    DATA_FROM_L2_LAST,
  output logic                    BUSY
);

  if (!line_geometry_ok(BUFFER_WIDTH, L2_BUS_WIDTH)) begin : g_bad_geometry
    $error("BUFFER_WIDTH must be L2_BUS_WIDTH * 2**k with k >= 1");
  end

  state_e                  state_q, state_d;
  logic [BUFFER_WIDTH-1:0] line_q, line_d;
  logic [CW-1:0]           beat_idx, beat_idx_d;
  logic [CW-1:0]           sent_cnt, sent_cnt_d;
  logic [CW-1:0]           start_beat;
  logic                    line_fire;
  logic                    beat_fire;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_beat = LINE_START_BEAT;
`else
  assign start_beat = '0;
`endif

  // Channel outputs decoded from registered state; LINE_READY also looks at
  // the downstream READY so a new line can load on the final beat.
  always_comb begin
    DATA_FROM_L2_VALID = (state_q == SEND);
    BUSY               = (state_q == SEND);
    DATA_FROM_L2       = line_q[beat_idx*L2_BUS_WIDTH +: L2_BUS_WIDTH];
    DATA_FROM_L2_LAST  = (state_q == SEND) && (sent_cnt == CW'(BEATS - 1));
    LINE_READY         = ENB && ((state_q == IDLE) ||
                                 (DATA_FROM_L2_LAST && DATA_FROM_L2_READY));
    line_fire          = LINE_VALID && LINE_READY;
    beat_fire          = DATA_FROM_L2_VALID && DATA_FROM_L2_READY && ENB;
  end

  // Next-state: load on line_fire, advance on beat_fire, else hold.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    beat_idx_d = beat_idx;
    sent_cnt_d = sent_cnt;
    unique case (state_q)
      IDLE: begin
        if (line_fire) begin
          state_d    = SEND;
          line_d     = LINE_DATA;
          beat_idx_d = start_beat;
          sent_cnt_d = '0;
        end
      end
      SEND: begin
        if (beat_fire) begin
          if (!DATA_FROM_L2_LAST) begin
            beat_idx_d = beat_idx + CW'(1);
            sent_cnt_d = sent_cnt + CW'(1);
          end else if (line_fire) begin
            line_d     = LINE_DATA;
            beat_idx_d = start_beat;
            sent_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; ENB=0 is already folded into the fire terms above.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      line_q   <= '0;
      beat_idx <= '0;
      sent_cnt <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      beat_idx <= beat_idx_d;
      sent_cnt <= sent_cnt_d;
    end
  end

endmodule
